inst_fetch_bridge: RTL and testbench

//  Sits between the core's instruction port (rom_en/rom_addr/rom_inst) and a variable-latency

---
 rtl/inst_fetch_bridge_if.sv | 45 ++++
 rtl/inst_fetch_bridge.sv | 166 ++++++++++++++++
 tb/tb_inst_fetch_bridge.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_bridge_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_bridge_if
//   Instruction-memory read bus between the fetch bridge and the memory.
//   One request is handed over with a req/gnt handshake. The read data comes
//   back later on rvalid/rdata.
//
//   Signals
//     req     bridge -> mem   read request, held until granted
//     addr    bridge -> mem   read address, stable while req=1
//     gnt     mem -> bridge   request accepted in a cycle where req=1
//     rvalid  mem -> bridge   read data valid, at least 1 cycle after gnt
//     rdata   mem -> bridge   read data
//
//   Modports
//     master  the fetch bridge (issues reads)
//     slave   the instruction memory (answers reads)
// ---------------------------------------------------------------------------
interface inst_fetch_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/inst_fetch_bridge.sv
// ---------------------------------------------------------------------------
// inst_fetch_bridge
//   Connects the core's single-cycle instruction port (rom_en/rom_addr/
//   rom_inst) to a variable-latency instruction memory bus. The bridge keeps
//   at most one read outstanding and a 1-entry fetch buffer. It raises
//   rom_stall until the instruction for rom_addr is in the buffer, so PC and
//   IF_ID hold while it waits. An optional watchdog replaces a hung fetch
//   with NOP_INST and sets a sticky error flag.
//
//   Parameters
//     ADDR_W    width of rom_addr / bus address
//     DATA_W    width of rom_inst / bus read data
//     NOP_INST  instruction returned on a miss or after a timeout
//     TIMEOUT   WAIT cycles allowed before the watchdog fires (0 = disabled)
//
//   Ports
//     clk        core clock
//     rst        synchronous reset, active-low (0 = reset)
//     rom_en     core fetch enable
//     rom_addr   core fetch address (the PC)
//     rom_inst   instruction for rom_addr, valid while rom_stall=0
//     rom_stall  1 = core must hold PC and IF_ID
//     fetch_err  sticky: watchdog fired; cleared only by reset
//     mem        instruction bus, master side
// ---------------------------------------------------------------------------
module inst_fetch_bridge #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = '0,
  parameter int                TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rom_en,
  input  logic [ADDR_W-1:0]    rom_addr,
  output logic [DATA_W-1:0]    rom_inst,
  output logic                 rom_stall,
  output logic                 fetch_err,
  inst_fetch_bridge_if.master  mem
);

  // The watchdog counter only has to reach TIMEOUT-1, so this width never
  // wraps. It keeps one bit when the watchdog is disabled.
  localparam int CNT_W_RAW  = $clog2(TIMEOUT + 1);
  localparam int CNT_W      = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam bit WDOG_EN    = (TIMEOUT != 0);
  localparam int CNT_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t             state_q,    state_nxt;
  logic               req_q,      req_nxt;
  logic [ADDR_W-1:0]  addr_q,     addr_nxt;
  logic               buf_valid_q, buf_valid_nxt;
  logic [ADDR_W-1:0]  buf_addr_q, buf_addr_nxt;
  logic [DATA_W-1:0]  buf_data_q, buf_data_nxt;
  logic [CNT_W-1:0]   cnt_q,      cnt_nxt;
  logic               err_q,      err_nxt;
  logic               hit;

  // rst is included here so the core sees no stall and a NOP while the
  // bridge is held in reset, whatever the registers still contain.
  assign hit       = rst & rom_en & buf_valid_q & (buf_addr_q == rom_addr);
  assign rom_inst  = hit ? buf_data_q : NOP_INST;
  assign rom_stall = rst & rom_en & ~hit;
  assign fetch_err = err_q;

  assign mem.req   = req_q;
  assign mem.addr  = addr_q;

  // Next-state logic. The buffer is served combinationally in every state.
  // A new read is started only from IDLE, so an address change in the
  // middle of a fetch lets the old fetch finish into the buffer first. The
  // new address then misses and is fetched on the next pass through IDLE.
  always_comb begin
    state_nxt     = state_q;
    req_nxt       = req_q;
    addr_nxt      = addr_q;
    buf_valid_nxt = buf_valid_q;
    buf_addr_nxt  = buf_addr_q;
    buf_data_nxt  = buf_data_q;
    cnt_nxt       = cnt_q;
    err_nxt       = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (rom_en && !hit) begin
          state_nxt = S_ISSUE;
          req_nxt   = 1'b1;
          addr_nxt  = rom_addr;
        end
      end

      S_ISSUE: begin
        if (mem.gnt) begin
          state_nxt = S_WAIT;
          req_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      end

      S_WAIT: begin
        if (mem.rvalid) begin
          state_nxt     = S_IDLE;
          buf_valid_nxt = 1'b1;
          buf_addr_nxt  = addr_q;
          buf_data_nxt  = mem.rdata;
        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
          // Give up on this read and hand the core a NOP so it can move on.
          // The bus still owes one response, and DRAIN absorbs it.
          state_nxt     = S_DRAIN;
          buf_valid_nxt = 1'b1;
          buf_addr_nxt  = addr_q;
          buf_data_nxt  = NOP_INST;
          err_nxt       = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end

      S_DRAIN: begin
        // The late response is dropped. A new read cannot start before it
        // arrives, so only one read is ever in flight.
        if (mem.rvalid) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // Register update. Reset drops any fetch in flight. A response that
  // arrives afterwards finds the FSM in IDLE and is ignored there.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= NOP_INST;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      req_q       <= req_nxt;
      addr_q      <= addr_nxt;
      buf_valid_q <= buf_valid_nxt;
      buf_addr_q  <= buf_addr_nxt;
      buf_data_q  <= buf_data_nxt;
      cnt_q       <= cnt_nxt;
      err_q       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_bridge
//   Directed bench for inst_fetch_bridge with TIMEOUT=8 and NOP_INST=0.
//   The memory side is driven by hand, cycle by cycle. Inputs change 1 ns
//   after the rising edge and outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_inst_fetch_bridge;

  localparam int          ADDR_W  = 32;
  localparam int          DATA_W  = 32;
  localparam int          TIMEOUT = 8;
  localparam logic [31:0] NOP     = 32'h0;

  logic              clk;
  logic              rst;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_inst;
  logic              rom_stall;
  logic              fetch_err;

  int assertCount;
  int failCount;

  inst_fetch_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  inst_fetch_bridge #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NOP_INST (NOP),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_inst  (rom_inst),
    .rom_stall (rom_stall),
    .fetch_err (fetch_err),
    .mem       (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to 1 ns after the next rising edge, where inputs are changed.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive every input for the current cycle, then let the combinational
  // outputs settle before they are checked.
  task automatic applyStimulus(input logic rst_v, input logic en,
                               input logic [31:0] addr, input logic gnt,
                               input logic rv, input logic [31:0] rdata);
    rst              = rst_v;
    rom_en           = en;
    rom_addr         = addr;
    mem_bus.gnt      = gnt;
    mem_bus.rvalid   = rv;
    mem_bus.rdata    = rdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;

    // 1. Two clock edges in reset with a fetch requested.
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_stall", 32'(rom_stall), 32'd0);
    checkOutput("rst_inst",  rom_inst,       NOP);
    checkOutput("rst_req",   32'(mem_bus.req), 32'd0);
    checkOutput("rst_addr",  mem_bus.addr,   32'h0);
    checkOutput("rst_err",   32'(fetch_err), 32'd0);

    // 2. Minimum-latency miss at 0x100: grant in the request cycle and
    //    data one cycle later.
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0);    // cycle 0: miss
    checkOutput("m_c0_stall", 32'(rom_stall), 32'd1);
    checkOutput("m_c0_req",   32'(mem_bus.req), 32'd0);
    nextCycle();                                              // cycle 1: ISSUE
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0);
    checkOutput("m_c1_req",   32'(mem_bus.req), 32'd1);
    checkOutput("m_c1_addr",  mem_bus.addr,   32'h100);
    checkOutput("m_c1_stall", 32'(rom_stall), 32'd1);
    nextCycle();                                              // cycle 2: WAIT
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 32'h2402_0005);
    checkOutput("m_c2_req",   32'(mem_bus.req), 32'd0);
    checkOutput("m_c2_stall", 32'(rom_stall), 32'd1);
    nextCycle();                                              // cycle 3: hit
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    checkOutput("m_c3_stall", 32'(rom_stall), 32'd0);
    checkOutput("m_c3_inst",  rom_inst,       32'h2402_0005);

    // 3. Holding the buffered address must not start another read.
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
      checkOutput("hold_req",   32'(mem_bus.req), 32'd0);
      checkOutput("hold_stall", 32'(rom_stall), 32'd0);
      checkOutput("hold_inst",  rom_inst,       32'h2402_0005);
    end

    // 4. Grant arrives 4 cycles late: the request stays stable for 5 cycles.
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h180, 1'b0, 1'b0, 32'h0);
    checkOutput("slow_c0_stall", 32'(rom_stall), 32'd1);
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b1, 32'h180, (i == 4), 1'b0, 32'h0);
      checkOutput("slow_req",   32'(mem_bus.req), 32'd1);
      checkOutput("slow_addr",  mem_bus.addr,   32'h180);
      checkOutput("slow_stall", 32'(rom_stall), 32'd1);
    end
    nextCycle();                                              // WAIT
    applyStimulus(1'b1, 1'b1, 32'h180, 1'b0, 1'b1, 32'h1111_2222);
    checkOutput("slow_req_drop", 32'(mem_bus.req), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h180, 1'b0, 1'b0, 32'h0);
    checkOutput("slow_stall_end", 32'(rom_stall), 32'd0);
    checkOutput("slow_inst",      rom_inst,       32'h1111_2222);

    // 5. Watchdog: the memory never answers within 8 WAIT cycles.
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h1C0, 1'b1, 1'b0, 32'h0);    // IDLE miss
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h1C0, 1'b1, 1'b0, 32'h0);    // ISSUE, gnt
    for (int i = 0; i < TIMEOUT; i++) begin                   // 8 WAIT cycles
      nextCycle();
      applyStimulus(1'b1, 1'b1, 32'h1C0, 1'b0, 1'b0, 32'h0);
      checkOutput("wd_wait_stall", 32'(rom_stall), 32'd1);
      checkOutput("wd_wait_err",   32'(fetch_err), 32'd0);
    end
    nextCycle();                                              // DRAIN, late data
    applyStimulus(1'b1, 1'b1, 32'h1C0, 1'b0, 1'b1, 32'h0000_DEAD);
    checkOutput("wd_stall", 32'(rom_stall), 32'd0);
    checkOutput("wd_inst",  rom_inst,       NOP);
    checkOutput("wd_err",   32'(fetch_err), 32'd1);
    nextCycle();                                              // IDLE again
    applyStimulus(1'b1, 1'b1, 32'h1C0, 1'b0, 1'b0, 32'h0);
    checkOutput("wd_drop_inst", rom_inst,       NOP);
    checkOutput("wd_drop_req",  32'(mem_bus.req), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 32'h0);    // new miss
    checkOutput("wd_next_stall", 32'(rom_stall), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 32'h0);
    checkOutput("wd_next_req",  32'(mem_bus.req), 32'd1);
    checkOutput("wd_next_addr", mem_bus.addr,   32'h104);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h104, 1'b0, 1'b1, 32'h8C22_0004);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 32'h0);
    checkOutput("wd_next_stall_end", 32'(rom_stall), 32'd0);
    checkOutput("wd_next_inst",      rom_inst,       32'h8C22_0004);
    checkOutput("wd_err_sticky",     32'(fetch_err), 32'd1);

    // 6. Reset in WAIT, then the response arrives after reset.
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0);    // IDLE miss
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0);    // ISSUE, gnt
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);    // WAIT
    checkOutput("rw_wait_stall", 32'(rom_stall), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);    // reset in WAIT
    checkOutput("rw_rst_stall", 32'(rom_stall), 32'd0);
    checkOutput("rw_rst_inst",  rom_inst,       NOP);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h300, 1'b0, 1'b1, 32'h0000_0BAD);
    checkOutput("rw_err",   32'(fetch_err), 32'd0);
    checkOutput("rw_req",   32'(mem_bus.req), 32'd0);
    checkOutput("rw_stall", 32'(rom_stall), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
    checkOutput("rw_no_fill_stall", 32'(rom_stall), 32'd1);
    checkOutput("rw_no_fill_inst",  rom_inst,       NOP);
    applyStimulus(1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 32'h0);
    checkOutput("rw_buf_cleared", 32'(rom_stall), 32'd1);
    checkOutput("rw_err_after",   32'(fetch_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
